// File: rtl/estacionamiento_multi.sv
// rtl/estacionamiento_multi.sv - multi-gate parking occupancy controller with saturating shared counter
module estacionamiento_multi #(
    parameter int NUM_GATES = 2,
    parameter int CAPACITY  = 7,
    parameter int CW        = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_GATES-1:0] a,
    input  logic [NUM_GATES-1:0] b,
    output logic [CW-1:0]        count,
    output logic                 full,
    output logic                 empty,
    output logic [NUM_GATES-1:0] ingreso,
    output logic [NUM_GATES-1:0] egreso,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int GW = $clog2(NUM_GATES + 1);
    localparam int SW = (CW + 2 > GW + 2) ? CW + 2 : GW + 2;
    localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

    typedef enum logic [2:0] {IDLE, E1, E2, E3, X1, X2, X3} gstate_t;

    logic [NUM_GATES-1:0] a_s1, a_s2, b_s1, b_s2;
    logic [NUM_GATES-1:0] ev_in, ev_eg;
    gstate_t              st    [NUM_GATES];
    gstate_t              st_nx [NUM_GATES];
    logic signed [SW-1:0] u, d, n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_s1 <= '0;
            a_s2 <= '0;
            b_s1 <= '0;
            b_s2 <= '0;
        end else begin
            a_s1 <= a;
            a_s2 <= a_s1;
            b_s1 <= b;
            b_s2 <= b_s1;
        end
    end

    // Event pulses are registered alongside the state so they coincide with leaving E3/X3.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_GATES; i++) st[i] <= IDLE;
            ingreso <= '0;
            egreso  <= '0;
        end else begin
            for (int i = 0; i < NUM_GATES; i++) st[i] <= st_nx[i];
            ingreso <= ev_in;
            egreso  <= ev_eg;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_GATES; i++) begin
            st_nx[i] = st[i];
            case (st[i])
                IDLE: case ({a_s2[i], b_s2[i]})
                    2'b10:   st_nx[i] = E1;
                    2'b01:   st_nx[i] = X1;
                    default: st_nx[i] = IDLE;
                endcase
                E1: case ({a_s2[i], b_s2[i]})
                    2'b11:   st_nx[i] = E2;
                    2'b00:   st_nx[i] = IDLE;
                    default: st_nx[i] = E1;
                endcase
                E2: case ({a_s2[i], b_s2[i]})
                    2'b01:   st_nx[i] = E3;
                    2'b10:   st_nx[i] = E1;
                    2'b00:   st_nx[i] = IDLE;
                    default: st_nx[i] = E2;
                endcase
                E3: case ({a_s2[i], b_s2[i]})
                    2'b00:   st_nx[i] = IDLE;
                    2'b11:   st_nx[i] = E2;
                    2'b10:   st_nx[i] = E1;
                    default: st_nx[i] = E3;
                endcase
                X1: case ({a_s2[i], b_s2[i]})
                    2'b11:   st_nx[i] = X2;
                    2'b00:   st_nx[i] = IDLE;
                    default: st_nx[i] = X1;
                endcase
                X2: case ({a_s2[i], b_s2[i]})
                    2'b10:   st_nx[i] = X3;
                    2'b01:   st_nx[i] = X1;
                    2'b00:   st_nx[i] = IDLE;
                    default: st_nx[i] = X2;
                endcase
                X3: case ({a_s2[i], b_s2[i]})
                    2'b00:   st_nx[i] = IDLE;
                    2'b11:   st_nx[i] = X2;
                    2'b01:   st_nx[i] = X1;
                    default: st_nx[i] = X3;
                endcase
                default: st_nx[i] = IDLE;
            endcase
        end
    end

    always_comb begin
        ev_in = '0;
        ev_eg = '0;
        for (int i = 0; i < NUM_GATES; i++) begin
            ev_in[i] = (st[i] == E3) && !a_s2[i] && !b_s2[i];
            ev_eg[i] = (st[i] == X3) && !a_s2[i] && !b_s2[i];
        end
    end

    // Entries and exits of the same cycle net out before clipping.
    always_comb begin
        u = '0;
        d = '0;
        for (int i = 0; i < NUM_GATES; i++) begin
            u = u + {{(SW-1){1'b0}}, ingreso[i]};
            d = d + {{(SW-1){1'b0}}, egreso[i]};
        end
        n = $signed({{(SW-CW){1'b0}}, count}) + u - d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (n > CAP_S) begin
            count     <= CW'(CAPACITY);
            overflow  <= 1'b1;
            underflow <= 1'b0;
        end else if (n[SW-1]) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b1;
        end else begin
            count     <= n[CW-1:0];
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end
    end

    assign full  = (count == CW'(CAPACITY));
    assign empty = (count == '0);

endmodule

// File: tb/tb_estacionamiento_multi.sv
// tb/tb_estacionamiento_multi.sv - bench for estacionamiento_multi: directed table, reset corners, 4-gate random scoreboard
module tb_estacionamiento_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] a, b;
    logic [2:0] count;
    logic       full, empty, overflow, underflow;
    logic [1:0] ingreso, egreso;

    logic [3:0] a4, b4;
    logic [4:0] count4;
    logic       full4, empty4, overflow4, underflow4;
    logic [3:0] ingreso4, egreso4;

    estacionamiento_multi dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .count(count), .full(full), .empty(empty),
        .ingreso(ingreso), .egreso(egreso), .overflow(overflow), .underflow(underflow)
    );

    estacionamiento_multi #(.NUM_GATES(4), .CAPACITY(20), .CW(5)) dut4 (
        .clk(clk), .reset(reset), .a(a4), .b(b4), .count(count4), .full(full4), .empty(empty4),
        .ingreso(ingreso4), .egreso(egreso4), .overflow(overflow4), .underflow(underflow4)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int ecnt  = 0;
    int tot_in = 0, tot_eg = 0, tot_ov = 0, tot_un = 0;

    always @(posedge clk) ecnt <= ecnt + 1;

    always @(negedge clk) begin
        tot_in = tot_in + $countones(ingreso);
        tot_eg = tot_eg + $countones(egreso);
        tot_ov = tot_ov + int'(overflow);
        tot_un = tot_un + int'(underflow);
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Each step holds its ab pair for 3 clocks; steps are 2-bit fields, first step in the MSBs.
    task automatic run_steps(input logic [15:0] s0, input logic [15:0] s1);
        logic [1:0] p0, p1;
        for (int j = 0; j < 8; j++) begin
            p0 = s0[15-2*j -: 2];
            p1 = s1[15-2*j -: 2];
            a[0] = p0[1]; b[0] = p0[0];
            a[1] = p1[1]; b[1] = p1[0];
            repeat (3) @(negedge clk);
        end
    endtask

    typedef struct {
        string       name;
        logic [15:0] s0;
        logic [15:0] s1;
        int          cnt;
        int          nin;
        int          neg;
        int          nov;
        int          nun;
    } vec_t;

    localparam logic [15:0] IDL = 16'b00_00_00_00_00_00_00_00;
    localparam logic [15:0] ENT = 16'b10_11_01_00_00_00_00_00;
    localparam logic [15:0] EXI = 16'b01_11_10_00_00_00_00_00;
    localparam logic [15:0] ABT = 16'b10_11_10_00_00_00_00_00;
    localparam logic [15:0] REV = 16'b10_11_10_11_01_00_00_00;

    vec_t tv [15];

    int  upd_u [8192];
    int  upd_d [8192];
    bit [3:0] exp_in [8192];
    bit [3:0] exp_eg [8192];
    int  scr  [4][4];
    int  pos  [4];
    int  hold [4];

    initial begin
        int b_in, b_eg, b_ov, b_un;
        int k, mcount, nm, r, item, ev;
        bit mov, mun;

        tv[0]  = '{"entry0",      ENT, IDL, 1, 1, 0, 0, 0};
        tv[1]  = '{"abort",       ABT, IDL, 1, 0, 0, 0, 0};
        tv[2]  = '{"reverse",     REV, IDL, 2, 1, 0, 0, 0};
        tv[3]  = '{"exit1",       IDL, EXI, 1, 0, 1, 0, 0};
        tv[4]  = '{"dual_in_a",   ENT, ENT, 3, 2, 0, 0, 0};
        tv[5]  = '{"dual_in_b",   ENT, ENT, 5, 2, 0, 0, 0};
        tv[6]  = '{"dual_in_c",   ENT, ENT, 7, 2, 0, 0, 0};
        tv[7]  = '{"over",        ENT, IDL, 7, 1, 0, 1, 0};
        tv[8]  = '{"simul_full",  ENT, EXI, 7, 1, 1, 0, 0};
        tv[9]  = '{"exit_full",   IDL, EXI, 6, 0, 1, 0, 0};
        tv[10] = '{"dual_out_a",  EXI, EXI, 4, 0, 2, 0, 0};
        tv[11] = '{"dual_out_b",  EXI, EXI, 2, 0, 2, 0, 0};
        tv[12] = '{"dual_out_c",  EXI, EXI, 0, 0, 2, 0, 0};
        tv[13] = '{"under",       EXI, EXI, 0, 0, 2, 0, 1};
        tv[14] = '{"simul_empty", ENT, EXI, 0, 1, 1, 0, 0};

        reset = 1'b0;
        a = '0; b = '0; a4 = '0; b4 = '0;

        for (int i = 0; i < 6; i++) begin
            a = 2'($urandom); b = 2'($urandom);
            a4 = 4'($urandom); b4 = 4'($urandom);
            @(negedge clk);
            chk("rst_count", count, 0);
            chk("rst_empty", empty, 1);
            chk("rst_full", full, 0);
            chk("rst_pulses", {ingreso, egreso, overflow, underflow}, 0);
            chk("rst_count4", count4, 0);
            chk("rst_pulses4", {ingreso4, egreso4, overflow4, underflow4}, 0);
        end
        a = '0; b = '0; a4 = '0; b4 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 15; v++) begin
            b_in = tot_in; b_eg = tot_eg; b_ov = tot_ov; b_un = tot_un;
            run_steps(tv[v].s0, tv[v].s1);
            chk({tv[v].name, "_count"}, count, tv[v].cnt);
            chk({tv[v].name, "_full"}, full, tv[v].cnt == 7);
            chk({tv[v].name, "_empty"}, empty, tv[v].cnt == 0);
            chk({tv[v].name, "_ingreso"}, tot_in - b_in, tv[v].nin);
            chk({tv[v].name, "_egreso"}, tot_eg - b_eg, tv[v].neg);
            chk({tv[v].name, "_overflow"}, tot_ov - b_ov, tv[v].nov);
            chk({tv[v].name, "_underflow"}, tot_un - b_un, tv[v].nun);
        end

        // Reset in the middle of an entry crossing, then release while gate0 shows ab=01.
        run_steps(ENT, IDL);
        chk("mid_pre_count", count, 1);
        a[0] = 1'b1; b[0] = 1'b0;
        repeat (3) @(negedge clk);
        a[0] = 1'b1; b[0] = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_async_count", count, 0);
        chk("mid_async_empty", empty, 1);
        chk("mid_async_pulses", {ingreso, egreso, overflow, underflow}, 0);
        a[0] = 1'b0; b[0] = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        b_in = tot_in; b_eg = tot_eg; b_ov = tot_ov; b_un = tot_un;
        repeat (6) @(negedge clk);
        a[0] = 1'b0; b[0] = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_noevt_in", tot_in - b_in, 0);
        chk("mid_noevt_eg", tot_eg - b_eg, 0);
        chk("mid_noevt_un", tot_un - b_un, 0);
        chk("mid_noevt_count", count, 0);
        run_steps(EXI, IDL);
        chk("mid_exit_eg", tot_eg - b_eg, 1);
        chk("mid_exit_in", tot_in - b_in, 0);
        chk("mid_exit_un", tot_un - b_un, 1);
        chk("mid_exit_count", count, 0);

        // Random crossings on the 4-gate instance against an event-time scoreboard.
        mcount = 0;
        for (int g = 0; g < 4; g++) begin
            pos[g] = 4;
            hold[g] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            k = ecnt;
            nm = mcount + upd_u[k] - upd_d[k];
            mov = 1'b0; mun = 1'b0;
            if (nm > 20) begin
                nm = 20; mov = 1'b1;
            end else if (nm < 0) begin
                nm = 0; mun = 1'b1;
            end
            mcount = nm;
            chk("rnd_count", count4, mcount);
            chk("rnd_full", full4, mcount == 20);
            chk("rnd_empty", empty4, mcount == 0);
            chk("rnd_ingreso", ingreso4, exp_in[k]);
            chk("rnd_egreso", egreso4, exp_eg[k]);
            chk("rnd_overflow", overflow4, mov);
            chk("rnd_underflow", underflow4, mun);

            for (int g = 0; g < 4; g++) begin
                if (hold[g] == 0) begin
                    if (pos[g] == 4) begin
                        r = (cyc < 1500) ? int'($urandom_range(0, 9)) : 9 - int'($urandom_range(0, 9));
                        if (r < 5) begin
                            scr[g][0] = 2; scr[g][1] = 3; scr[g][2] = 1; scr[g][3] = 4;
                        end else if (r < 7) begin
                            scr[g][0] = 1; scr[g][1] = 3; scr[g][2] = 2; scr[g][3] = 8;
                        end else if (r < 8) begin
                            scr[g][0] = 2; scr[g][1] = 3; scr[g][2] = 2; scr[g][3] = 0;
                        end else begin
                            scr[g][0] = 1; scr[g][1] = 3; scr[g][2] = 1; scr[g][3] = 0;
                        end
                        pos[g] = 0;
                    end
                    item = scr[g][pos[g]];
                    pos[g] = pos[g] + 1;
                    a4[g] = item[1];
                    b4[g] = item[0];
                    hold[g] = int'($urandom_range(2, 4));
                    ev = k + 1;
                    if (item[2]) begin
                        exp_in[ev+2][g] = 1'b1;
                        upd_u[ev+3] = upd_u[ev+3] + 1;
                    end
                    if (item[3]) begin
                        exp_eg[ev+2][g] = 1'b1;
                        upd_d[ev+3] = upd_d[ev+3] + 1;
                    end
                end
                hold[g] = hold[g] - 1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/estacionamiento_multi.md
# estacionamiento_multi

Parametrised parking-occupancy controller for lots with several gates. Each gate has a two-beam sensor pair (outer `a`, inner `b`). A per-gate sequence FSM decodes each complete vehicle crossing into an entry or exit event. A shared saturating up/down counter aggregates all events issued in the same cycle into one occupancy value, with full/empty flags and capacity-violation pulses. It replaces the single-gate, fixed 3-bit detector-plus-counter pair at the top of the parking design.

## Interface
Parameters:
- `NUM_GATES`, default 2: number of gates (sensor pairs), ≥1.
- `CAPACITY`, default 7: maximum occupancy, ≥1.
- `CW`, default 3: count width; must satisfy 2^CW > CAPACITY.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `reset`, input, 1: asynchronous, active-low. Low clears all state immediately; release is synchronous to `clk`.
- `a`, input, NUM_GATES: outer beam per gate, 1 = blocked; asynchronous to `clk`.
- `b`, input, NUM_GATES: inner beam per gate, 1 = blocked; asynchronous to `clk`.
- `count`, output, CW: current occupancy, registered.
- `full`, output, 1: `count == CAPACITY`.
- `empty`, output, 1: `count == 0`.
- `ingreso`, output, NUM_GATES: one-cycle entry-event pulse per gate, registered.
- `egreso`, output, NUM_GATES: one-cycle exit-event pulse per gate, registered.
- `overflow`, output, 1: one-cycle pulse when entries were clipped at CAPACITY.
- `underflow`, output, 1: one-cycle pulse when exits were clipped at 0.

## Operation
- **Synchronisers.** Each `a[i]` and `b[i]` passes through a 2-flop synchroniser; the FSM uses only the second stage. The pair is written `ab = {a_s, b_s}`.
- **Gate FSM.** One instance per gate, states IDLE, E1, E2, E3, X1, X2, X3.
  - IDLE: ab=10 → E1; ab=01 → X1; otherwise stay.
  - E1: 11 → E2; 00 → IDLE; otherwise stay.
  - E2: 01 → E3; 10 → E1 (car backing out); 00 → IDLE; otherwise stay.
  - E3: 00 → IDLE with `ingreso[i]`=1 for one cycle; 11 → E2; 10 → E1.
  - X1/X2/X3 mirror E1/E2/E3 with `a` and `b` swapped. X3 on 00 → IDLE with `egreso[i]`=1.
  - An abort to IDLE (not via E3/X3) produces no event.
- **Aggregation.** U = popcount(`ingreso`), D = popcount(`egreso`). Compute in signed arithmetic at least CW+2 bits wide (and wide enough for NUM_GATES): n = count + U − D.
- **Saturation.**
  - n > CAPACITY → `count` ← CAPACITY, `overflow`=1.
  - n < 0 → `count` ← 0, `underflow`=1.
  - Otherwise `count` ← n.
  - Simultaneous entry and exit cancel before saturation. Example: at full with U=1, D=1, count stays full and no overflow.
- **Flags.** `full` and `empty` are decoded from registered `count`, so they are glitch-free.
- **Reset values.** While `reset`=0:
  - `count`=0, `empty`=1, `full`=0.
  - `ingreso`=0, `egreso`=0, `overflow`=0, `underflow`=0.
  - Synchronisers cleared to 0, all FSMs in IDLE.
- **Reset mid-crossing.** The crossing is lost. After release, the FSM restarts from the current synchronised `ab`, and only a fresh 10 (or 01) from IDLE begins a new sequence.

## Timing
- Let edge E be the first edge that samples the final ab=00 of a crossing at the pins.
  - FSM leaves E3/X3 at edge E+2.
  - `ingreso`/`egreso` is high during the cycle after E+2.
  - `count`, `full`, `empty`, `overflow`, `underflow` update at edge E+3.
- Event pulses are exactly one cycle wide.
- A gate needs at least 4 distinct synchronised steps per crossing, so it issues at most one event per 4 cycles. Different gates are independent and may fire in the same cycle.
- Input levels must be stable for at least 2 clocks to be seen. Shorter glitches may be missed; the FSM tolerates this (stay/abort rules) and never double-counts.

## Test plan
- **Reset.** Hold `reset`=0 with random `a`/`b` → `count`=0, `empty`=1, all pulses 0. Release, gate0 entry 00→10→11→01→00 (3 cycles each) → `ingreso[0]` pulses once; `count`=1 three edges after the final 00 is sampled.
- **Aborted and reversed sequences.** 00→10→11→10→00 → no event, `count` unchanged. 00→10→11→10→11→01→00 → exactly one `ingreso`.
- **Full boundary.** With CAPACITY=7, make 7 entries → `full`=1. An eighth entry → `count` stays 7, `overflow` pulses once. An exit on gate1 → `count`=6, `full`=0.
- **Simultaneous events.** At count=7, entry on gate0 and exit on gate1 in the same cycle → `count`=7, no `overflow`. At count=0, two exits in the same cycle → `count`=0, `underflow`=1.
- **Reset mid-crossing.** Assert `reset` while gate0 is in E2 → all outputs clear asynchronously. Release with ab=01 → no event and no spurious X-sequence completion until a full 00→01→11→10→00 exit.
- **Parameter sweep.** NUM_GATES=4, CAPACITY=20, CW=5, random legal crossings on all gates → `count` matches a scoreboard of clipped net events every cycle.
